// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: reset defaults, fetch FSM encoding and base opcodes
// used by the fetch stage, decoder and immediate extender.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry hold buffer that parks a fetched
// word while decode is stalled.
module if_id_reg
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            capture_i,
    input  logic            release_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            buf_valid_q, buf_valid_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;

    always_comb begin
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        pc_plus4_d  = pc_plus4_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            instr_d     = NOP_INSTR;
            buf_valid_d = 1'b0;
        end else begin
            if (load_i) begin
                valid_d    = 1'b1;
                instr_d    = instr_i;
                pc_d       = pc_i;
                pc_plus4_d = pc_i + XLEN'(4);
            end else if (release_i && buf_valid_q) begin
                valid_d     = 1'b1;
                instr_d     = buf_instr_q;
                pc_d        = buf_pc_q;
                pc_plus4_d  = buf_pc_q + XLEN'(4);
                buf_valid_d = 1'b0;
            end else if (advance_i) begin
                // Decode took the word and nothing replaces it: present a bubble.
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            if (capture_i) begin
                buf_valid_d = 1'b1;
                buf_instr_d = instr_i;
                buf_pc_d    = pc_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            pc_plus4_q  <= XLEN'(4);
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pc_plus4_q  <= pc_plus4_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the single-outstanding imem
// req/ack handshake and applies execute redirects to the IF/ID register.
module instr_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            id_stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc_plus4_o,
    output logic            fetch_misalign_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            kill_q, kill_d;
    logic            misalign_q, misalign_d;

    logic            ifid_load, ifid_capture, ifid_release, ifid_flush;
    logic            ifid_valid;
    logic            ifid_free;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_target;

    assign pc_plus4        = pc_q + XLEN'(4);
    assign redirect_target = align_word(redirect_pc_i);
    assign ifid_free       = !ifid_valid || !id_stall_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        kill_d       = kill_q;
        misalign_d   = 1'b0;
        ifid_load    = 1'b0;
        ifid_capture = 1'b0;
        ifid_release = 1'b0;
        ifid_flush   = 1'b0;
        if (redirect_valid_i) begin
            ifid_flush = 1'b1;
            pc_d       = redirect_target;
            misalign_d = |redirect_pc_i[1:0];
            if (req_q && !imem_ack_i) begin
                // Cannot retract the live request; mark its response for discard.
                kill_d = 1'b1;
            end else begin
                kill_d  = 1'b0;
                req_d   = 1'b1;
                addr_d  = redirect_target;
                state_d = S_WAIT;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ifid_free) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                            addr_d = pc_q;
                        end else if (ifid_free) begin
                            ifid_load = 1'b1;
                            pc_d      = pc_plus4;
                            if (!id_stall_i) begin
                                addr_d = pc_plus4;
                            end else begin
                                req_d   = 1'b0;
                                state_d = S_IDLE;
                            end
                        end else begin
                            ifid_capture = 1'b1;
                            req_d        = 1'b0;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall_i) begin
                        ifid_release = 1'b1;
                        pc_d         = pc_plus4;
                        state_d      = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            kill_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            kill_q     <= kill_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (ifid_flush),
        .load_i     (ifid_load),
        .capture_i  (ifid_capture),
        .release_i  (ifid_release),
        .advance_i  (!id_stall_i),
        .instr_i    (imem_rdata_i),
        .pc_i       (pc_q),
        .valid_o    (ifid_valid),
        .instr_o    (ifid_instr_o),
        .pc_o       (ifid_pc_o),
        .pc_plus4_o (ifid_pc_plus4_o)
    );

    assign imem_req_o       = req_q;
    assign imem_addr_o      = addr_q;
    assign ifid_valid_o     = ifid_valid;
    assign fetch_misalign_o = misalign_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: wait-state memory model, scoreboard of
// accepted fetches, and per-cycle handshake/flush/stall checks.
module tb_instr_fetch_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        fetch_misalign;

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_ack_i       (imem_ack),
        .imem_rdata_i     (imem_rdata),
        .id_stall_i       (id_stall),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .ifid_valid_o     (ifid_valid),
        .ifid_instr_o     (ifid_instr),
        .ifid_pc_o        (ifid_pc),
        .ifid_pc_plus4_o  (ifid_pc_plus4),
        .fetch_misalign_o (fetch_misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          mem_wait = 0;
    int          wait_cnt = 0;
    int          n_obs = 0;
    int          n_at4;
    int          obs_base;
    logic [31:0] last_obs_pc = 32'h1;
    logic [31:0] exp_fetch_pc = 32'h0;
    logic        kill_pend = 1'b0;
    logic        exp_mis = 1'b0;
    logic        exp_flush = 1'b0;
    logic        prev_rst, prev_redir, prev_valid, prev_stall, prev_req, prev_ack;
    logic [31:0] prev_addr, prev_instr, prev_pc, prev_p4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hC0DE_0013);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_instr", ifid_instr, NOP_INSTR_DEFAULT);
        chk("rst_pc", ifid_pc, 0);
        chk("rst_pc4", ifid_pc_plus4, 4);
        chk("rst_misalign", fetch_misalign, 0);
    endtask

    // One clock: memory responds, scoreboard is updated, then post-edge checks.
    task automatic tick();
        exp_t e;
        imem_ack   = imem_req && (wait_cnt >= mem_wait);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;
        if (rst) begin
            sb_q.delete();
            exp_fetch_pc = RESET_PC_DEFAULT;
            kill_pend    = 1'b0;
        end else if (redirect_valid) begin
            sb_q.delete();
            exp_fetch_pc = {redirect_pc[31:2], 2'b00};
            kill_pend    = imem_req && !imem_ack;
        end else if (imem_ack) begin
            if (!kill_pend) begin
                e.pc    = imem_addr;
                e.instr = mem_word(imem_addr);
                sb_q.push_back(e);
                exp_fetch_pc = imem_addr + 32'd4;
            end
            kill_pend = 1'b0;
        end
        exp_mis    = !rst && redirect_valid && (redirect_pc[1:0] != 2'b00);
        exp_flush  = !rst && redirect_valid;
        prev_rst   = rst;
        prev_redir = redirect_valid;
        prev_valid = ifid_valid;
        prev_stall = id_stall;
        prev_req   = imem_req;
        prev_ack   = imem_ack;
        prev_addr  = imem_addr;
        prev_instr = ifid_instr;
        prev_pc    = ifid_pc;
        prev_p4    = ifid_pc_plus4;
        if (rst || !imem_req || imem_ack) wait_cnt = 0;
        else wait_cnt++;

        @(posedge clk);
        #1;

        chk("misalign", fetch_misalign, exp_mis);
        if (exp_flush) chk("flush_valid", ifid_valid, 0);
        if (!prev_rst && !prev_redir && prev_valid && prev_stall) begin
            chk("stall_valid", ifid_valid, 1);
            chk("stall_instr", ifid_instr, prev_instr);
            chk("stall_pc", ifid_pc, prev_pc);
            chk("stall_pc4", ifid_pc_plus4, prev_p4);
        end
        if (!prev_rst && ifid_valid && (!prev_valid || !prev_stall)) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", ifid_valid, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_instr", ifid_instr, e.instr);
                chk("sb_pc", ifid_pc, e.pc);
                chk("sb_pc4", ifid_pc_plus4, e.pc + 32'd4);
                n_obs++;
                last_obs_pc = e.pc;
            end
        end
        if (imem_req && (!prev_req || prev_ack)) chk("req_addr", imem_addr, exp_fetch_pc);
        else if (imem_req) chk("req_stable", imem_addr, prev_addr);
        chk("addr_align", {30'b0, imem_addr[1:0]}, 0);
    endtask

    initial begin
        rst            = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;

        // Reset, then zero-wait streaming.
        tick();
        tick();
        check_reset();
        rst = 1'b0;
        tick();
        chk("zw_req0", imem_req, 1);
        chk("zw_addr0", imem_addr, 32'h0);
        tick();
        chk("zw_addr4", imem_addr, 32'h4);
        chk("zw_instr0", ifid_instr, 32'h0050_0093);
        chk("zw_pc0", ifid_pc, 32'h0);
        chk("zw_pc4_0", ifid_pc_plus4, 32'h4);
        tick();
        chk("zw_addr8", imem_addr, 32'h8);
        chk("zw_req8", imem_req, 1);

        // Three wait states: eight in-order fetches.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        mem_wait = 3;
        n_at4    = 0;
        obs_base = n_obs;
        for (int i = 0; i < 60 && n_obs < obs_base + 8; i++) begin
            if (imem_req && imem_addr == 32'h4) n_at4++;
            tick();
        end
        chk("ws_fetch8_done", n_obs - obs_base, 8);
        chk("ws_addr4_cycles", n_at4, 4);
        chk("ws_last_pc", last_obs_pc, 32'h1C);

        // Stall during the wait: response parks in the hold buffer.
        id_stall = 1'b1;
        repeat (4) tick();
        chk("hold_pc", ifid_pc, 32'h1C);
        chk("hold_req", imem_req, 0);
        repeat (2) tick();
        id_stall = 1'b0;
        tick();
        chk("release_pc", ifid_pc, 32'h20);
        chk("release_valid", ifid_valid, 1);
        tick();
        chk("release_req", imem_req, 1);
        chk("release_addr", imem_addr, 32'h24);

        // Redirect while the fetch of 0x8 is outstanding.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        mem_wait = 2;
        for (int i = 0; i < 30 && !(imem_req && imem_addr == 32'h8 && wait_cnt == 0); i++)
            tick();
        chk("kill_reached8", imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("kill_valid0", ifid_valid, 0);
        chk("kill_addr_held", imem_addr, 32'h8);
        last_obs_pc = 32'h1;
        for (int i = 0; i < 20 && last_obs_pc != 32'h100; i++) tick();
        chk("kill_got100", last_obs_pc, 32'h100);

        // Misaligned redirect together with a stall.
        id_stall       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_pulse", fetch_misalign, 1);
        chk("mis_valid0", ifid_valid, 0);
        tick();
        chk("mis_clear", fetch_misalign, 0);
        last_obs_pc = 32'h1;
        for (int i = 0; i < 20 && last_obs_pc != 32'h100; i++) tick();
        chk("mis_got100", last_obs_pc, 32'h100);
        id_stall = 1'b0;

        // Wrap at the top of the address space, zero-wait.
        mem_wait       = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        last_obs_pc    = 32'h1;
        for (int i = 0; i < 10 && last_obs_pc != 32'hFFFF_FFFC; i++) tick();
        chk("wrap_seen", last_obs_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc_plus4, 32'h0);
        chk("wrap_next_req", imem_req, 1);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset in the middle of an outstanding request.
        mem_wait = 3;
        rst      = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        tick();
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, RESET_PC_DEFAULT);
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
